// File: rtl/cpu_pkg.sv
// Shared core constants and types.
// Used by the write-back stage and its select mux.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// Write-back value select.
// Picks load data or ALU result per MemtoReg.
module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              sel_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = sel_i ? mem_i : alu_i;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: register file with
// write-through read ports and a retire counter.
module wb_regfile #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] ALU_Result_i,
  input  logic [DATA_W-1:0] MemRead_Data_i,
  input  logic [ADDR_W-1:0] Rd_Addr_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] WB_Data_o,
  output logic              WB_Valid_o,
  output logic [CNT_W-1:0]  Wr_Count_o
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_A =
    ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;

  wb_mux #(
    .DATA_W(DATA_W)
  ) u_wb_mux (
    .sel_i (MemtoReg_i),
    .alu_i (ALU_Result_i),
    .mem_i (MemRead_Data_i),
    .data_o(wb_data)
  );

  assign wb_valid = start_i & RegWrite_i
                  & (Rd_Addr_i != ZERO_A)
                  & rst_i;

  assign WB_Data_o  = wb_data;
  assign WB_Valid_o = wb_valid;
  assign Wr_Count_o = cnt_q;

  // x0 wins over bypass; bypass wins over array
  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] r;
    r = '0;
    unique case (1'b1)
      (a == ZERO_A):
        r = '0;
      (wb_valid && a == Rd_Addr_i):
        r = wb_data;
      default:
        r = regs_q[a];
    endcase
    return r;
  endfunction

  assign RS1data_o = rd_port(RS1addr_i);
  assign RS2data_o = rd_port(RS2addr_i);

  always_comb begin
    cnt_d = cnt_q;
    if (wb_valid) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (wb_valid)
        regs_q[Rd_Addr_i] <= wb_data;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed
// cases then randomized traffic vs. a model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] alu = '0;
  logic [31:0] mem = '0;
  logic [4:0]  rd = '0;
  logic        we = 1'b0;
  logic        mtr = 1'b0;
  logic [4:0]  a1 = '0;
  logic [4:0]  a2 = '0;
  logic [31:0] rs1_o;
  logic [31:0] rs2_o;
  logic [31:0] wbd_o;
  logic        vld_o;
  logic [31:0] cnt_o;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .ALU_Result_i  (alu),
    .MemRead_Data_i(mem),
    .Rd_Addr_i     (rd),
    .RegWrite_i    (we),
    .MemtoReg_i    (mtr),
    .RS1addr_i     (a1),
    .RS2addr_i     (a2),
    .RS1data_o     (rs1_o),
    .RS2data_o     (rs2_o),
    .WB_Data_o     (wbd_o),
    .WB_Valid_o    (vld_o),
    .Wr_Count_o    (cnt_o)
  );

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wbd;
    logic        vld;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  logic [31:0] mcnt;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, req);
    end
  endtask

  // Register-file reference: x0 reads zero, a
  // write in flight is visible to readers.
  function automatic logic [31:0] mread(
    input logic [4:0] a, input logic v,
    input logic [4:0] d, input logic [31:0] w
  );
    if (a == 0) return 32'h0;
    if (v && a == d) return w;
    return mregs[a];
  endfunction

  task automatic drive(
    input logic r, input logic s,
    input logic w, input logic m,
    input logic [31:0] al, input logic [31:0] me,
    input logic [4:0] d,
    input logic [4:0] x1, input logic [4:0] x2,
    input string tag
  );
    exp_t e;
    logic v;
    logic [31:0] wv;
    rst = r; start = s; we = w; mtr = m;
    alu = al; mem = me; rd = d;
    a1 = x1; a2 = x2;
    v  = s && w && (d != 0) && r;
    wv = m ? me : al;
    e.rs1 = mread(x1, v, d, wv);
    e.rs2 = mread(x2, v, d, wv);
    e.wbd = wv;
    e.vld = v;
    e.cnt = mcnt;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    if (!r) begin
      foreach (mregs[i]) mregs[i] = 32'h0;
      mcnt = 32'h0;
    end else if (v) begin
      mregs[d] = wv;
      mcnt = mcnt + 1;
    end
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".rs1"}, rs1_o, e.rs1);
        chk({e.tag, ".rs2"}, rs2_o, e.rs2);
        chk({e.tag, ".wbd"}, wbd_o, e.wbd);
        chk({e.tag, ".vld"}, {31'h0, vld_o},
            {31'h0, e.vld});
        chk({e.tag, ".cnt"}, cnt_o, e.cnt);
      end
    end
  end

  initial begin : stim
    int t;
    logic [4:0] d;
    foreach (mregs[i]) mregs[i] = 32'h0;
    mcnt = 32'h0;
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, 0, 0, 5, 31, "rst");
    drive(1, 1, 0, 0, 0, 0, 0, 5, 31, "rst_rd");
    drive(1, 1, 1, 0, 32'h1234, 32'h0, 7, 0, 0,
          "alu_wr");
    drive(1, 1, 0, 0, 0, 0, 0, 7, 0, "alu_rd");
    drive(1, 1, 1, 1, 32'h0, 32'hDEADBEEF, 3, 7, 3,
          "ld_byp");
    drive(1, 1, 0, 0, 0, 0, 0, 7, 3, "ld_rd");
    drive(1, 1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,
          "x0_wr");
    drive(1, 1, 0, 0, 0, 0, 0, 0, 3, "x0_rd");
    drive(1, 1, 1, 0, 32'h11, 0, 9, 0, 0, "r9_pre");
    drive(1, 0, 1, 0, 32'h55, 0, 9, 9, 9, "frz");
    drive(1, 0, 0, 0, 0, 0, 0, 9, 0, "frz_rd");
    drive(1, 1, 1, 0, 32'h55, 0, 9, 9, 0, "unfrz");
    drive(1, 1, 0, 0, 0, 0, 0, 9, 7, "unfrz_rd");
    drive(0, 1, 1, 0, 32'hA5A5, 0, 4, 4, 7,
          "rst_wr");
    drive(1, 1, 0, 0, 0, 0, 0, 4, 7, "rst_wr_rd");
    drive(1, 1, 0, 0, 0, 0, 0, 3, 9, "rst_old");
    for (int i = 0; i < 400; i++) begin
      d = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom),
            $urandom, $urandom, d,
            ($urandom_range(0, 2) == 0) ? d
              : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d
              : 5'($urandom_range(0, 31)),
            "rnd");
    end
    t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
